// File: rtl/shadow_snapshot_buf.sv
// Ring buffer of DEPTH state snapshots, frozen on request and dumped oldest-first over CHAINS serial chains.
// Optional build macro SHADOW_PARITY_EN appends one even-parity bit per chain after each snapshot.
module shadow_snapshot_buf #(
  parameter int unsigned DIN_W  = 64,
  parameter int unsigned CHAINS = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         capture_en,
  input  logic                         freeze,
  input  logic [DIN_W-1:0]             din,
  input  logic                         dump_start,
  output logic [CHAINS-1:0]            chains_out,
  output logic [CHAINS-1:0]            chains_out_vld,
  output logic [CHAINS-1:0]            chains_out_done,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   snap_cnt
);

  localparam int unsigned CH_LEN     = (DIN_W + CHAINS - 1) / CHAINS;
  localparam int unsigned CHAIN_BITS = CHAINS * CH_LEN;
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SHADOW_PARITY_EN
  localparam int unsigned SNAP_LEN   = CH_LEN + 1;
`else
  localparam int unsigned SNAP_LEN   = CH_LEN;
`endif
  localparam int unsigned BIT_W      = $clog2(SNAP_LEN + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  typedef logic [CHAINS-1:0][CH_LEN-1:0] chains_t;

  logic [DIN_W-1:0] mem_q [DEPTH];

  logic [1:0]        state_q,    state_d;
  logic [PTR_W-1:0]  wr_ptr_q,   wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,   rd_ptr_d;
  logic [CNT_W-1:0]  snap_cnt_q, snap_cnt_d;
  logic [CNT_W-1:0]  rem_q,      rem_d;
  logic [BIT_W-1:0]  bit_q,      bit_d;
  logic              frozen_q,   frozen_d;
  chains_t           sh_q,       sh_d;
`ifdef SHADOW_PARITY_EN
  logic [CHAINS-1:0] par_q,      par_d;
`endif
  logic [CHAINS-1:0] out_q,      out_d;
  logic [CHAINS-1:0] vld_q,      vld_d;
  logic [CHAINS-1:0] done_q,     done_d;
  logic              busy_q,     busy_d;

  logic              cap_we_c;
  logic [PTR_W-1:0]  start_ptr_c;
  chains_t           rd_chains_c;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Chain c bit k is din[c*CH_LEN+k]; the zero-extension pads the last chain.
  function automatic chains_t to_chains(input logic [DIN_W-1:0] v);
    return CHAIN_BITS'(v);
  endfunction

  function automatic logic [CHAINS-1:0] chain_lsbs(input chains_t s);
    logic [CHAINS-1:0] r;
    for (int c = 0; c < CHAINS; c++) r[c] = s[c][0];
    return r;
  endfunction

  function automatic chains_t chain_shift(input chains_t s);
    chains_t r;
    for (int c = 0; c < CHAINS; c++) r[c] = s[c] >> 1;
    return r;
  endfunction

`ifdef SHADOW_PARITY_EN
  function automatic logic [CHAINS-1:0] chain_par(input chains_t s);
    logic [CHAINS-1:0] r;
    for (int c = 0; c < CHAINS; c++) r[c] = ^s[c];
    return r;
  endfunction
`endif

  // Oldest retained snapshot sits snap_cnt entries behind the write pointer.
  always_comb begin
    if (DEPTH == 1) start_ptr_c = '0;
    else            start_ptr_c = PTR_W'(wr_ptr_q - PTR_W'(snap_cnt_q));
  end

  assign rd_chains_c = to_chains(mem_q[rd_ptr_q]);

  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    snap_cnt_d = snap_cnt_q;
    rem_d      = rem_q;
    bit_d      = bit_q;
    frozen_d   = frozen_q;
    sh_d       = sh_q;
`ifdef SHADOW_PARITY_EN
    par_d      = par_q;
`endif
    out_d      = '0;
    vld_d      = '0;
    done_d     = '0;
    cap_we_c   = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (!frozen_q && capture_en) begin
          cap_we_c = 1'b1;
          wr_ptr_d = ptr_inc(wr_ptr_q);
          if (snap_cnt_q != CNT_W'(DEPTH)) snap_cnt_d = snap_cnt_q + CNT_W'(1);
        end
        if (freeze) frozen_d = 1'b1;
        if (dump_start && frozen_q) begin
          state_d  = S_LOAD;
          rd_ptr_d = start_ptr_c;
        end
      end
      S_LOAD: begin
        if (snap_cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          sh_d     = rd_chains_c;
`ifdef SHADOW_PARITY_EN
          par_d    = chain_par(rd_chains_c);
`endif
          rd_ptr_d = ptr_inc(rd_ptr_q);
          rem_d    = snap_cnt_q - CNT_W'(1);
          bit_d    = '0;
          state_d  = S_SHIFT;
        end
      end
      S_SHIFT: begin
        vld_d = '1;
`ifdef SHADOW_PARITY_EN
        if (bit_q == BIT_W'(CH_LEN)) out_d = par_q;
        else                         out_d = chain_lsbs(sh_q);
`else
        out_d = chain_lsbs(sh_q);
`endif
        sh_d = chain_shift(sh_q);
        // Reload on the edge that emits the final bit so snapshots stream without a gap.
        if (bit_q == BIT_W'(SNAP_LEN - 1)) begin
          if (rem_q == '0) begin
            state_d = S_DONE;
          end else begin
            sh_d     = rd_chains_c;
`ifdef SHADOW_PARITY_EN
            par_d    = chain_par(rd_chains_c);
`endif
            rd_ptr_d = ptr_inc(rd_ptr_q);
            rem_d    = rem_q - CNT_W'(1);
            bit_d    = '0;
          end
        end else begin
          bit_d = bit_q + BIT_W'(1);
        end
      end
      S_DONE: begin
        done_d     = '1;
        snap_cnt_d = '0;
        frozen_d   = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // Snapshot storage needs no reset; snap_cnt governs which entries are meaningful.
  always_ff @(posedge clk) begin
    if (cap_we_c) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      snap_cnt_q <= '0;
      rem_q      <= '0;
      bit_q      <= '0;
      frozen_q   <= 1'b0;
      sh_q       <= '0;
`ifdef SHADOW_PARITY_EN
      par_q      <= '0;
`endif
      out_q      <= '0;
      vld_q      <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      snap_cnt_q <= snap_cnt_d;
      rem_q      <= rem_d;
      bit_q      <= bit_d;
      frozen_q   <= frozen_d;
      sh_q       <= sh_d;
`ifdef SHADOW_PARITY_EN
      par_q      <= par_d;
`endif
      out_q      <= out_d;
      vld_q      <= vld_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
    end
  end

  assign chains_out      = out_q;
  assign chains_out_vld  = vld_q;
  assign chains_out_done = done_q;
  assign busy            = busy_q;
  assign snap_cnt        = snap_cnt_q;

endmodule

// File: tb/tb_shadow_snapshot_buf.sv
// Bench for shadow_snapshot_buf: queue-based reference model, per-cycle compare, directed literal checks.
module tb_shadow_snapshot_buf;

  localparam int DIN_W  = 64;
  localparam int CHAINS = 8;
  localparam int DEPTH  = 4;
  localparam int CH_LEN = 8;
`ifdef SHADOW_PARITY_EN
  localparam int SNAP_LEN = CH_LEN + 1;
`else
  localparam int SNAP_LEN = CH_LEN;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              capture_en = 1'b0;
  logic              freeze = 1'b0;
  logic [DIN_W-1:0]  din = '0;
  logic              dump_start = 1'b0;
  logic [CHAINS-1:0] chains_out;
  logic [CHAINS-1:0] chains_out_vld;
  logic [CHAINS-1:0] chains_out_done;
  logic              busy;
  logic [2:0]        snap_cnt;

  shadow_snapshot_buf #(.DIN_W(DIN_W), .CHAINS(CHAINS), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .capture_en(capture_en), .freeze(freeze), .din(din),
    .dump_start(dump_start), .chains_out(chains_out), .chains_out_vld(chains_out_vld),
    .chains_out_done(chains_out_done), .busy(busy), .snap_cnt(snap_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic              vld;
    logic [CHAINS-1:0] data;
    logic              done;
    logic              busy;
  } rec_t;

  rec_t             exp_q[$];
  rec_t             cur = '0;
  logic [DIN_W-1:0] snaps[$];
  bit               frozen_m = 1'b0;
  bit               chk_en = 1'b0;
  int               checks = 0;
  int               errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  // Chain word at serial position k of a snapshot: data bits first, then optional parity.
  function automatic logic [CHAINS-1:0] exp_word(input logic [DIN_W-1:0] s, input int k);
    logic [CHAINS-1:0] w;
    for (int c = 0; c < CHAINS; c++) begin
      if (k < CH_LEN) begin
        w[c] = (c * CH_LEN + k < DIN_W) ? s[c * CH_LEN + k] : 1'b0;
      end else begin
        w[c] = 1'b0;
        for (int j = 0; j < CH_LEN; j++)
          if (c * CH_LEN + j < DIN_W) w[c] = w[c] ^ s[c * CH_LEN + j];
      end
    end
    return w;
  endfunction

  // One clock edge of the reference: either replay a scheduled dump record or apply idle rules.
  task automatic model_update();
    rec_t r;
    bit   old_fz;
    r = '0;
    if (exp_q.size() > 0) begin
      r = exp_q.pop_front();
      if (r.done) begin
        snaps.delete();
        frozen_m = 1'b0;
      end
    end else begin
      old_fz = frozen_m;
      if (!frozen_m && capture_en) begin
        snaps.push_back(din);
        if (snaps.size() > DEPTH) void'(snaps.pop_front());
      end
      if (freeze) frozen_m = 1'b1;
      if (dump_start && old_fz) begin
        rec_t t;
        t = '0; t.busy = 1'b1;
        exp_q.push_back(t);
        exp_q.push_back(t);
        foreach (snaps[i])
          for (int k = 0; k < SNAP_LEN; k++) begin
            t = '0; t.busy = 1'b1; t.vld = 1'b1; t.data = exp_word(snaps[i], k);
            exp_q.push_back(t);
          end
        t = '0; t.done = 1'b1;
        exp_q.push_back(t);
        r = exp_q.pop_front();
      end
    end
    cur = r;
  endtask

  task automatic model_reset();
    exp_q.delete();
    snaps.delete();
    frozen_m = 1'b0;
    cur = '0;
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_update();
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      chk("vld",      64'(chains_out_vld),  cur.vld ? 64'hFF : 64'h0);
      chk("data",     64'(chains_out),      64'(cur.data));
      chk("done",     64'(chains_out_done), cur.done ? 64'hFF : 64'h0);
      chk("busy",     64'(busy),            64'(cur.busy));
      chk("snap_cnt", 64'(snap_cnt),        64'(snaps.size()));
    end
  end

  task automatic cap(input logic [DIN_W-1:0] v, input logic fz);
    capture_en = 1'b1; din = v; freeze = fz;
    step();
    capture_en = 1'b0; freeze = 1'b0;
  endtask

  task automatic do_freeze();
    freeze = 1'b1;
    step();
    freeze = 1'b0;
  endtask

  // Issues dump_start (edge k=0), collects chain0/chain7 streams; poke_at re-pulses dump_start.
  task automatic do_dump(input int poke_at, output logic [63:0] c0, output logic [63:0] c7,
                         output int nv, output int first, output int done_at);
    c0 = '0; c7 = '0; nv = 0; first = -1; done_at = -1;
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      dump_start = (k == poke_at);
      step();
      dump_start = 1'b0;
      if (chains_out_vld[0]) begin
        if (nv == 0) first = k;
        if (nv < 64) begin
          c0[nv] = chains_out[0];
          c7[nv] = chains_out[7];
        end
        nv++;
      end
      if (chains_out_done[0]) begin
        done_at = k;
        break;
      end
    end
    chk("dump_done_seen", 64'(done_at >= 0), 64'h1);
  endtask

  task automatic mid_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_vld",      64'(chains_out_vld),  64'h0);
    chk("rst_data",     64'(chains_out),      64'h0);
    chk("rst_done",     64'(chains_out_done), 64'h0);
    chk("rst_busy",     64'(busy),            64'h0);
    chk("rst_snap_cnt", 64'(snap_cnt),        64'h0);
    model_reset();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_timeout time=%0t", $time);
    $fatal(1);
  end

  initial begin
    logic [63:0] c0, c7;
    int          nv, first, done_at;

    repeat (2) @(posedge clk);
    #1;
    chk("init_vld",      64'(chains_out_vld), 64'h0);
    chk("init_busy",     64'(busy),           64'h0);
    chk("init_snap_cnt", 64'(snap_cnt),       64'h0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Two snapshots, dumped oldest first.
    cap(64'h0123456789ABCDEF, 1'b0);
    cap(64'hFFFF0000FFFF0000, 1'b0);
    chk("t2_snap_cnt", 64'(snap_cnt), 64'h2);
    do_freeze();
    do_dump(-1, c0, c7, nv, first, done_at);
    chk("t2_nvld",  64'(nv),      64'(2 * SNAP_LEN));
    chk("t2_first", 64'(first),   64'h2);
    chk("t2_done",  64'(done_at), 64'(2 + 2 * SNAP_LEN));
`ifdef SHADOW_PARITY_EN
    chk("t2_chain0", c0 & 64'h3FFFF, 64'h001EF);
    chk("t2_chain7", c7 & 64'h3FFFF, 64'h1FF01);
`else
    chk("t2_chain0", c0 & 64'hFFFF, 64'h00EF);
    chk("t2_chain7", c7 & 64'hFFFF, 64'hFF01);
`endif
    chk("t2_cnt_after", 64'(snap_cnt), 64'h0);
    step();

    // Six captures overflow a depth-4 ring; only 3..6 survive.
    for (int v = 1; v <= 6; v++) cap(64'(v), 1'b0);
    chk("t3_saturate", 64'(snap_cnt), 64'h4);
    do_freeze();
    do_dump(-1, c0, c7, nv, first, done_at);
    chk("t3_nvld", 64'(nv), 64'(4 * SNAP_LEN));
`ifdef SHADOW_PARITY_EN
    chk("t3_chain0", c0 & 64'hF_FFFF_FFFF,
        64'h3 | (64'h4 << 9) | (64'h1 << 17) | (64'h5 << 18) | (64'h6 << 27));
`else
    chk("t3_chain0", c0 & 64'hFFFF_FFFF, 64'h06050403);
`endif
    step();

    // Empty dump, then an unfrozen dump_start that must be ignored.
    do_freeze();
    do_dump(-1, c0, c7, nv, first, done_at);
    chk("t4_nvld", 64'(nv),      64'h0);
    chk("t4_done", 64'(done_at), 64'h2);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    step();
    chk("t4_nofrz_busy", 64'(busy), 64'h0);

    // Capture and freeze together; a dump_start mid-shift leaves the stream unchanged.
    cap(64'hAA, 1'b1);
    chk("t5_snap_cnt", 64'(snap_cnt), 64'h1);
    do_dump(4, c0, c7, nv, first, done_at);
    chk("t5_nvld",   64'(nv),          64'(SNAP_LEN));
    chk("t5_chain0", c0 & 64'hFF,      64'hAA);
    chk("t5_chain7", c7 & 64'hFF,      64'h00);
    step();

    // Reset in the middle of a dump.
    cap(64'h1234, 1'b0);
    cap(64'h5678, 1'b1);
    dump_start = 1'b1;
    step();
    dump_start = 1'b0;
    repeat (4) step();
    chk("t1_vld_before", 64'(chains_out_vld), 64'hFF);
    mid_reset();

    // Randomised traffic with occasional asynchronous resets.
    for (int i = 0; i < 4000; i++) begin
      capture_en = 1'($urandom_range(0, 1));
      freeze     = ($urandom_range(0, 99) < 4);
      dump_start = ($urandom_range(0, 99) < 15);
      din        = {$urandom, $urandom};
      if ($urandom_range(0, 799) == 0) begin
        capture_en = 1'b0; freeze = 1'b0; dump_start = 1'b0;
        mid_reset();
      end else begin
        step();
      end
    end
    capture_en = 1'b0; freeze = 1'b0; dump_start = 1'b0;
    repeat (60) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
